serial_adder16: RTL and testbench

//  Bit-serial 16-bit unsigned adder: one full-adder slice plus a carry flip-flop.

---
 rtl/serial_adder16.sv | 135 +++++++++++++
 tb/tb_serial_adder16.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_adder16.sv
// -----------------------------------------------------------------------------
// serial_adder16
//
// Bit-serial 16-bit unsigned adder built from a single full-adder slice and a
// carry flip-flop. Each operation samples both operands in one LOAD cycle, then
// spends 16 ADD cycles adding one bit pair per clock, LSB first. After the 16th
// ADD cycle the 16-bit sum and carry-out are published as registers and
// `valid` pulses high for one cycle. The block free-runs back-to-back
// operations, so one operation completes every 17 cycles.
//
// Ports
//   sum    out [15:0]  registered sum of the last completed operation
//   cout   out         registered carry-out of the last completed operation
//   a      in  [15:0]  operand 1, sampled only in LOAD
//   b      in  [15:0]  operand 2, sampled only in LOAD
//   clk    in          rising-edge clock
//   rst_n  in          asynchronous active-low reset
//   valid  out         one-cycle pulse: sum/cout were just updated
// -----------------------------------------------------------------------------
module serial_adder16 (
  output logic [15:0] sum,
  output logic        cout,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        clk,
  input  logic        rst_n,
  output logic        valid
);

  typedef enum logic {
    LOAD = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] rb_q, rb_d;
  // Partial-sum shift register. Only 15 bits are stored: the bit produced on
  // the final ADD cycle goes straight into `sum`, so a 16th stored bit would
  // always be shifted out before anyone reads it.
  logic [14:0] sr_q, sr_d;
  logic        c_q, c_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        valid_q, valid_d;

  logic        bit_s;
  logic        bit_co;

  // One-bit full adder: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
    return {co, s};
  endfunction

  // The single adder slice always works on the current operand LSBs.
  always_comb begin
    {bit_co, bit_s} = full_add(ra_q[0], rb_q[0], c_q);
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = 1'b0;

    case (state_q)
      LOAD: begin
        ra_d    = a;
        rb_d    = b;
        c_d     = 1'b0;
        cnt_d   = 4'd0;
        state_d = ADD;
      end

      ADD: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        sr_d  = {bit_s, sr_q[14:1]};
        c_d   = bit_co;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Last bit: the 15 earlier sum bits sit in sr_q[14:0], LSB at [0].
          sum_d   = {bit_s, sr_q};
          cout_d  = bit_co;
          valid_d = 1'b1;
          state_d = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      ra_q    <= '0;
      rb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum   = sum_q;
  assign cout  = cout_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_serial_adder16.sv
// -----------------------------------------------------------------------------
// tb_serial_adder16
//
// Directed-vector bench for serial_adder16 with hand-computed results, followed
// by a block of random operand pairs checked against a 17-bit a+b model.
// Inputs change between clock edges; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder16;

  logic [15:0] sum;
  logic        cout;
  logic [15:0] a;
  logic [15:0] b;
  logic        clk;
  logic        rst_n;
  logic        valid;

  int total;
  int bad;

  serial_adder16 dut (
    .sum   (sum),
    .cout  (cout),
    .a     (a),
    .b     (b),
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one full operation assuming the next rising edge is a LOAD edge.
  // Optionally changes `a` to new_a just after ADD cycle chg_at (0 = never).
  // Checks: valid low after LOAD and after ADD cycle 15 (with the previous
  // result still held), then the result and valid pulse after ADD cycle 16.
  task automatic do_op(input string tag, input logic [15:0] op_a,
                       input logic [15:0] op_b, input int chg_at,
                       input logic [15:0] new_a, input logic [15:0] prev_sum,
                       input logic [15:0] exp_sum, input logic exp_cout);
    a = op_a;
    b = op_b;
    @(posedge clk);
    #1;
    check({tag, " load valid"}, {31'd0, valid}, 32'd0);
    check({tag, " load hold"}, {16'd0, sum}, {16'd0, prev_sum});
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == chg_at) a = new_a;
      if (i == 15) check({tag, " pre valid"}, {31'd0, valid}, 32'd0);
    end
    check({tag, " valid"}, {31'd0, valid}, 32'd1);
    check({tag, " sum"}, {16'd0, sum}, {16'd0, exp_sum});
    check({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [16:0] ref17;
    logic [15:0] last;

    total = 0;
    bad   = 0;
    a     = 16'h0003;
    b     = 16'h0001;
    rst_n = 1'b1;

    // Asynchronous reset with no clock edge in between.
    #1 rst_n = 1'b0;
    #1;
    check("reset sum", {16'd0, sum}, 32'd0);
    check("reset cout", {31'd0, cout}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);

    // Release between edges; the next rising edge is LOAD.
    @(negedge clk);
    rst_n = 1'b1;

    do_op("basic", 16'h0003, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0004, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0004, 16'h0000, 1'b1);
    do_op("max", 16'hFFFF, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'hFFFE, 1'b1);
    do_op("msb", 16'h8000, 16'h8000, 0, 16'h0000, 16'hFFFE, 16'h0000, 1'b1);
    do_op("alt", 16'hAAAA, 16'h5555, 0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    do_op("zero", 16'h0000, 16'h0000, 0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);

    // Operand change mid-operation must not affect the running add.
    do_op("sample", 16'h1234, 16'h1111, 5, 16'h0000, 16'h0000, 16'h2345, 1'b0);
    do_op("resample", 16'h0000, 16'h1111, 0, 16'h0000, 16'h2345, 16'h1111,
          1'b0);

    // Reset during ADD cycle 8 clears outputs immediately.
    a = 16'h00FF;
    b = 16'h0001;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst sum", {16'd0, sum}, 32'd0);
    check("midrst cout", {31'd0, cout}, 32'd0);
    check("midrst valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First result 17 edges after release, then every 17 cycles.
    do_op("post rst", 16'h00FF, 16'h0001, 0, 16'h0000, 16'h0000, 16'h0100,
          1'b0);
    do_op("period", 16'h7FFF, 16'h0001, 0, 16'h0000, 16'h0100, 16'h8000, 1'b0);

    last = 16'h8000;
    for (int n = 0; n < 1000; n++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      ref17 = {1'b0, ra} + {1'b0, rb};
      do_op("rand", ra, rb, 0, 16'h0000, last, ref17[15:0], ref17[16]);
      last = ref17[15:0];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
